seg_capture: RTL
================

// Module: seg_capture
// PURPOSE
//  Receive side of the two-digit 7-segment bus. Samples a pair of active-low
//  segment patterns (bit7=a .. bit1=g, bit0=dp) and decodes each digit back to
//  a hex nibble. Emits one byte per distinct stable display value over a
//  valid/ready handshake. Sits behind a segment-driving block for loopback
//  checking in npc, or on a captured panel bus.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive identical samples required before capture (>=1)
// PORTS
//  clk        in   1  system clock, rising edge
//  rst        in   1  asynchronous reset, active-high
//  seg0_in    in   8  digit 0 segment pattern, active-low (low nibble)
//  seg1_in    in   8  digit 1 segment pattern, active-low (high nibble)
//  sample_en  in   1  capture enable; 0 aborts tracking
//  out_valid  out  1  captured byte available
//  out_ready  in   1  consumer accepts byte when out_valid&&out_ready at clk edge
//  out_byte   out  8  {nibble(seg1_in), nibble(seg0_in)}
//  out_err    out  2  bit i = digit i pattern not in decode table
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, cnt=0, cand=0, out_valid=0,
//    out_byte=8'h00, out_err=2'b00.
//  - Decode per digit: p=~seg_in. Compare p[7:1] against the 7-bit a..g table
//    0:1111110 1:0110000 2:1101101 3:1111001 4:0110011 5:1011011 6:1011111
//    7:1110000 8:1111111 9:1111011 A:1110111 b:0011111 C:1001110 d:0111101
//    E:1001111 F:1000111. dp is ignored. No match -> nibble=0, err bit=1.
//  - blank = ({seg1_in,seg0_in}==16'h0000), the disabled-driver value. Never captured.
//  - cur = {seg1_in,seg0_in}; cnt width = $clog2(STABLE_CYCLES+1).
//  - FSM (all transitions at rising clk):
//    IDLE : sample_en && !blank -> cand=cur, cnt=1, go TRACK.
//           If STABLE_CYCLES==1, go HOLD directly and latch outputs.
//           Otherwise stay.
//    TRACK: !sample_en or blank -> IDLE, cnt=0.
//           cur!=cand -> cand=cur, cnt=1 (restart).
//           cur==cand -> cnt++. When cnt+1==STABLE_CYCLES, latch out_byte and
//           out_err from cand, set out_valid=1, go HOLD.
//    HOLD : out_valid=1. out_byte and out_err stay frozen. Input changes and
//           sample_en are ignored, so a captured value is never dropped.
//           out_ready -> out_valid=0, go DONE.
//    DONE : wait for the display to change. !sample_en or cur!=cand -> IDLE.
//           Otherwise stay; a persisting value is never re-emitted.
//  - Latency: pattern stable across edges 1..STABLE_CYCLES gives out_valid high
//    after edge STABLE_CYCLES. Minimum valid pulse is 1 cycle (ready already high).
//  - out_byte and out_err hold their last value after acceptance until the next
//    capture. Valid only while out_valid=1.
//  - All outputs are registered. No combinational path from inputs to outputs.
// TESTING
//  1 seg1_in=8'h99,seg0_in=8'h25 ('4','2'), sample_en=1, out_ready=1 -> after 4
//    edges out_valid=1 for exactly 1 cycle, out_byte=8'h42, out_err=2'b00.
//    Pattern held 20 more cycles -> no second out_valid.
//  2 Glitch: 8'h99/8'h25 for 2 edges, then seg0_in=8'h0D ('3') -> out_valid
//    asserts only after 4 stable edges of the new pattern, out_byte=8'h43.
//  3 Backpressure: capture 8'h42 with out_ready=0 for 10 cycles while inputs
//    change -> out_valid and out_byte=8'h42 held throughout; ready=1 -> accepted,
//    out_valid=0 next cycle.
//  4 Invalid: seg0_in=8'hFF, seg1_in=8'h03 ('0') -> out_byte=8'h00,
//    out_err=2'b01. dp variant seg0_in=8'h24 ('2' with dp lit) -> nibble 2, no err.
//  5 Blank/abort: {seg1,seg0}=16'h0000 with sample_en=1 for 50 cycles -> no
//    out_valid. sample_en dropped in TRACK at cnt=2 -> IDLE, count restarts.
//  6 rst pulsed mid-HOLD (out_valid=1, out_byte=8'h42) -> outputs 0 immediately,
//    without waiting for a clk edge. After release with the same pattern, a fresh
//    capture needs the full 4 edges.

Source files
------------

// File: rtl/seg_capture_if.sv
// Handshake bundle for the 7-segment capture block: two segment bytes in, one decoded byte out.
// The master side is the panel/bench; the slave side is seg_capture.
interface seg_capture_if;
    logic [7:0] seg0_in;
    logic [7:0] seg1_in;
    logic       sample_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic [1:0] out_err;

    modport master (
        output seg0_in, seg1_in, sample_en, out_ready,
        input  out_valid, out_byte, out_err
    );

    modport slave (
        input  seg0_in, seg1_in, sample_en, out_ready,
        output out_valid, out_byte, out_err
    );
endinterface

// File: rtl/seg_capture.sv
// Receive side of a two-digit active-low 7-segment bus: debounces the display,
// decodes each digit to a hex nibble and emits one byte per distinct stable value.
module seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    seg_capture_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_cand;
    logic             r_out_valid;
    logic [7:0]       r_out_byte;
    logic [1:0]       r_out_err;

    logic [15:0]      w_cur;
    logic             w_blank;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_stable_hit;
    logic [7:0]       w_dec_byte;
    logic [1:0]       w_dec_err;

    assign w_cur        = {bus.seg1_in, bus.seg0_in};
    assign w_blank      = (w_cur == 16'h0000);
    assign w_cnt_inc    = r_cnt + CNT_W'(1);
    assign w_stable_hit = (w_cnt_inc == CNT_W'(STABLE_CYCLES));

    // Decoding the live inputs is enough: a capture only happens when cur equals cand.
    for (genvar gi = 0; gi < 2; gi++) begin : g_dec
        logic [6:0] w_p;
        logic [3:0] w_nib;
        logic       w_bad;

        assign w_p = ~w_cur[gi*8+1 +: 7];

        always_comb begin
            w_nib = 4'h0;
            w_bad = 1'b0;
            case (w_p)
                7'b1111110: w_nib = 4'h0;
                7'b0110000: w_nib = 4'h1;
                7'b1101101: w_nib = 4'h2;
                7'b1111001: w_nib = 4'h3;
                7'b0110011: w_nib = 4'h4;
                7'b1011011: w_nib = 4'h5;
                7'b1011111: w_nib = 4'h6;
                7'b1110000: w_nib = 4'h7;
                7'b1111111: w_nib = 4'h8;
                7'b1111011: w_nib = 4'h9;
                7'b1110111: w_nib = 4'hA;
                7'b0011111: w_nib = 4'hB;
                7'b1001110: w_nib = 4'hC;
                7'b0111101: w_nib = 4'hD;
                7'b1001111: w_nib = 4'hE;
                7'b1000111: w_nib = 4'hF;
                default:    w_bad = 1'b1;
            endcase
        end
    end

    assign w_dec_byte = {g_dec[1].w_nib, g_dec[0].w_nib};
    assign w_dec_err  = {g_dec[1].w_bad, g_dec[0].w_bad};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cand      <= 16'h0000;
            r_out_valid <= 1'b0;
            r_out_byte  <= 8'h00;
            r_out_err   <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.sample_en && !w_blank) begin
                        r_cand <= w_cur;
                        r_cnt  <= CNT_W'(1);
                        if (STABLE_CYCLES == 1) begin
                            r_out_byte  <= w_dec_byte;
                            r_out_err   <= w_dec_err;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_state <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (!bus.sample_en || w_blank) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_cur != r_cand) begin
                        r_cand <= w_cur;
                        r_cnt  <= CNT_W'(1);
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_stable_hit) begin
                            r_out_byte  <= w_dec_byte;
                            r_out_err   <= w_dec_err;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    // Inputs are deliberately ignored here so a pending byte is never lost.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (!bus.sample_en || (w_cur != r_cand)) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_byte  = r_out_byte;
    assign bus.out_err   = r_out_err;
endmodule
